// File: rtl/bus_arb_mux_pkg.sv
// Shared definitions for the bus_arb_mux datapath multiplexer.
//   MODE_FIXED / MODE_RR : values of the mode input
//   DEFAULT_WIDTH        : width of the shared datapath bus
//   wrap_add()           : (a + b) mod n for operands already below n,
//                          written as an explicit compare/subtract so it
//                          works for non-power-of-2 channel counts.
package bus_arb_mux_pkg;

   localparam logic MODE_FIXED    = 1'b0;
   localparam logic MODE_RR       = 1'b1;
   localparam int   DEFAULT_WIDTH = 8;

   function automatic int wrap_add(input int a, input int b, input int n);
      int s;
      s = a + b;
      if (s >= n) s = s - n;
      return s;
   endfunction

endpackage

// File: rtl/bus_arb_mux_if.sv
// Handshake/bus bundle between the datapath sources, the mux and its consumer.
//   mode, ctrl          selection mode and FIXED-mode channel index
//   in_data/in_valid    per-channel words, channel i at [i*WIDTH +: WIDTH]
//   in_ready            per-channel accept strobe (one-hot or zero)
//   out_data/out_src    registered word and the channel it came from
//   out_valid/out_ready output slot handshake
// Handshake rule for every valid/ready pair here: a word moves on a rising
// clock edge exactly when valid and ready are both 1 in the cycle before that
// edge; a producer keeps valid and data stable until it sees ready.
interface bus_arb_mux_if #(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 4
);
   localparam int SEL_W = $clog2(NUM_IN);

   logic                    mode;
   logic [SEL_W-1:0]        ctrl;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_valid;
   logic [NUM_IN-1:0]       in_ready;
   logic [WIDTH-1:0]        out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [SEL_W-1:0]        out_src;

   modport master (
      output mode, ctrl, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_src
   );

   modport slave (
      input  mode, ctrl, in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_src
   );
endinterface

// File: rtl/bus_arb_mux_rr_arbiter.sv
// Purely combinational round-robin arbiter.
//   req         in   NUM_IN  requesting channels
//   ptr         in   SEL_W   highest-priority channel (must be < NUM_IN)
//   grant       out  NUM_IN  one-hot grant, zero when nothing requests
//   grant_idx   out  SEL_W   index of the granted channel
//   grant_valid out  1       some channel is granted
module bus_arb_mux_rr_arbiter
   import bus_arb_mux_pkg::*;
#(
   parameter int NUM_IN = 4,
   localparam int SEL_W = $clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [NUM_IN-1:0] grant,
   output logic [SEL_W-1:0]  grant_idx,
   output logic              grant_valid
);

   logic [SEL_W-1:0] cand;

   // Scan offsets from farthest to nearest so the channel closest to ptr
   // (in wrap order) is the last writer and therefore wins.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int i = NUM_IN - 1; i >= 0; i--) begin
         cand = SEL_W'(wrap_add(int'(ptr), i, NUM_IN));
         if (req[cand]) begin
            grant       = '0;
            grant[cand] = 1'b1;
            grant_idx   = cand;
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arb_mux.sv
// N-to-1 datapath bus multiplexer with one registered output slot.
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  slave side of bus_arb_mux_if (mode/ctrl, channel inputs,
//        in_ready strobes, registered out_data/out_src/out_valid)
// FIXED mode takes channel ctrl only; RR mode grants round-robin among valid
// channels starting at rr_ptr. The slot reloads whenever it is empty or being
// drained, so back-to-back transfers run at one per cycle.
module bus_arb_mux
   import bus_arb_mux_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int NUM_IN = 4,
   localparam int SEL_W = $clog2(NUM_IN)
) (
   input  logic         clk,
   input  logic         rst,
   bus_arb_mux_if.slave bus
);

   logic [SEL_W-1:0]  rr_ptr;
   logic [NUM_IN-1:0] rr_grant;
   logic [SEL_W-1:0]  rr_idx;
   logic              rr_valid;

   logic [NUM_IN-1:0] fx_grant;
   logic              fx_valid;

   logic [NUM_IN-1:0] grant;
   logic [SEL_W-1:0]  grant_idx;
   logic              grant_valid;
   logic              load;
   logic              xfer;
   logic [WIDTH-1:0]  sel_data;

   bus_arb_mux_rr_arbiter #(.NUM_IN(NUM_IN)) u_rr (
      .req         (bus.in_valid),
      .ptr         (rr_ptr),
      .grant       (rr_grant),
      .grant_idx   (rr_idx),
      .grant_valid (rr_valid)
   );

   // FIXED grant: an out-of-range ctrl matches no channel, so nothing is granted.
   always_comb begin
      fx_grant = '0;
      fx_valid = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (bus.ctrl == SEL_W'(i) && bus.in_valid[i]) begin
            fx_grant[i] = 1'b1;
            fx_valid    = 1'b1;
         end
      end
   end

   always_comb begin
      grant       = (bus.mode == MODE_RR) ? rr_grant : fx_grant;
      grant_idx   = (bus.mode == MODE_RR) ? rr_idx   : bus.ctrl;
      grant_valid = (bus.mode == MODE_RR) ? rr_valid : fx_valid;
      load        = !bus.out_valid || bus.out_ready;
      // rst gating keeps in_ready low during reset even though the slot is empty.
      xfer        = load && grant_valid && !rst;
      bus.in_ready = xfer ? grant : '0;
      sel_data    = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant_idx == SEL_W'(i)) sel_data = bus.in_data[i*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_src   <= '0;
         rr_ptr        <= '0;
      end else if (xfer) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= sel_data;
         bus.out_src   <= grant_idx;
         if (bus.mode == MODE_RR)
            rr_ptr <= SEL_W'(wrap_add(int'(grant_idx), 1, NUM_IN));
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bus_arb_mux.sv
// Self-checking bench for bus_arb_mux: a 4-channel instance driven from a
// vector table with a scoreboard for the output words, plus a 3-channel
// instance for pointer wrap and out-of-range ctrl.
module tb_bus_arb_mux;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bus_arb_mux_if #(.WIDTH(8), .NUM_IN(4)) bus4 ();
   bus_arb_mux_if #(.WIDTH(8), .NUM_IN(3)) bus3 ();

   bus_arb_mux #(.WIDTH(8), .NUM_IN(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
   bus_arb_mux #(.WIDTH(8), .NUM_IN(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

   typedef struct {
      logic       mode;
      logic [1:0] ctrl;
      logic [3:0] valid;
      logic       ordy;
      logic [3:0] exp_rdy;
   } vec_t;

   vec_t       vecs[$];
   logic [9:0] exp_q[$];   // {src, data}
   logic [9:0] cur;
   logic       exp_ov;
   logic       prev_xfer;
   logic       prev_ordy;
   int         n_checks = 0;
   int         n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
      return r;
   endfunction

   task automatic add(input logic m, input logic [1:0] c, input logic [3:0] v,
                      input logic r, input logic [3:0] e);
      vec_t t;
      t.mode = m; t.ctrl = c; t.valid = v; t.ordy = r; t.exp_rdy = e;
      vecs.push_back(t);
   endtask

   // Entered just after a rising edge; leaves just after the next one.
   task automatic step(input vec_t v, input int n);
      logic [7:0] d [4];
      logic [1:0] g;
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(0, 255));
      bus4.mode      = v.mode;
      bus4.ctrl      = v.ctrl;
      bus4.in_valid  = v.valid;
      bus4.out_ready = v.ordy;
      bus4.in_data   = {d[3], d[2], d[1], d[0]};
      @(negedge clk);
      if (prev_xfer) begin
         exp_ov = 1'b1;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: vector %0d has no expected word", n);
         end else begin
            cur = exp_q.pop_front();
         end
      end else if (prev_ordy) begin
         exp_ov = 1'b0;
      end
      check($sformatf("out_valid[%0d]", n), 32'(bus4.out_valid), 32'(exp_ov));
      if (exp_ov) begin
         check($sformatf("out_data[%0d]", n), 32'(bus4.out_data), 32'(cur[7:0]));
         check($sformatf("out_src[%0d]", n),  32'(bus4.out_src),  32'(cur[9:8]));
      end
      check($sformatf("in_ready[%0d]", n), 32'(bus4.in_ready), 32'(v.exp_rdy));
      prev_xfer = |v.exp_rdy;
      prev_ordy = v.ordy;
      if (prev_xfer) begin
         g = onehot_idx(v.exp_rdy);
         exp_q.push_back({g, d[g]});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus4.mode = 1'b0; bus4.ctrl = '0; bus4.in_data = '0; bus4.in_valid = '0; bus4.out_ready = 1'b0;
      bus3.mode = 1'b0; bus3.ctrl = '0; bus3.in_data = '0; bus3.in_valid = '0; bus3.out_ready = 1'b0;

      // Reset state
      #1;
      check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
      check("rst_out_data",  32'(bus4.out_data),  32'd0);
      check("rst_out_src",   32'(bus4.out_src),   32'd0);
      check("rst_in_ready",  32'(bus4.in_ready),  32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;

      // FIXED ctrl=2, all valid, channel 2 carries A5
      bus4.mode = 1'b0; bus4.ctrl = 2'd2; bus4.in_valid = 4'b1111; bus4.out_ready = 1'b1;
      bus4.in_data = {8'h11, 8'hA5, 8'h22, 8'h33};
      @(negedge clk);
      check("fx_in_ready", 32'(bus4.in_ready), 32'h4);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("fx_out_valid", 32'(bus4.out_valid), 32'd1);
      check("fx_out_data",  32'(bus4.out_data),  32'hA5);
      check("fx_out_src",   32'(bus4.out_src),   32'd2);
      bus4.out_ready = 1'b0;
      #1;
      check("bp_in_ready", 32'(bus4.in_ready), 32'd0);

      // Asynchronous reset with a word in the slot
      #1 rst = 1'b1;
      #1;
      check("arst_out_valid", 32'(bus4.out_valid), 32'd0);
      check("arst_out_data",  32'(bus4.out_data),  32'd0);
      check("arst_out_src",   32'(bus4.out_src),   32'd0);
      check("arst_in_ready",  32'(bus4.in_ready),  32'd0);
      @(posedge clk);
      #1;
      check("arst_in_ready_hold", 32'(bus4.in_ready), 32'd0);
      check("arst_out_valid_hold", 32'(bus4.out_valid), 32'd0);
      bus4.in_valid = '0;
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;

      // Vector table (rr_ptr starts at 0)
      add(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100);
      add(1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001);
      add(1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000);
      add(1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010);
      for (int k = 0; k < 8; k++) add(1'b1, 2'd0, 4'b1111, 1'b1, 4'(1 << (k % 4)));
      add(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010);   // ptr -> 2
      add(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000);   // ch3, ptr -> 0
      add(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010);   // ch1, ptr -> 2
      add(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000);   // ch3, ptr -> 0
      for (int k = 0; k < 3; k++) add(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000);
      add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001);   // reload without bubble, ptr -> 1
      add(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000);   // word pending
      add(1'b0, 2'd3, 4'b1111, 1'b0, 4'b0000);   // switch to FIXED, still pending
      add(1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000);
      add(1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001);
      add(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100);
      add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010);   // RR resumes from frozen ptr=1
      add(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100);
      add(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000);
      add(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000);

      exp_ov = 1'b0; prev_xfer = 1'b0; prev_ordy = 1'b0;
      for (int n = 0; n < vecs.size(); n++) step(vecs[n], n);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      bus4.in_valid = '0;

      // 3-channel instance: pointer wrap 2 -> 0 and out-of-range ctrl
      bus3.mode = 1'b1; bus3.in_valid = 3'b100; bus3.out_ready = 1'b1;
      bus3.in_data = {8'h3C, 8'h00, 8'h00};
      @(negedge clk);
      check("n3_rr_ch2", 32'(bus3.in_ready), 32'h4);
      @(posedge clk);
      #1;
      bus3.in_valid = 3'b111;
      bus3.in_data = {8'h01, 8'h02, 8'h03};
      @(negedge clk);
      check("n3_out_src", 32'(bus3.out_src), 32'd2);
      check("n3_out_data", 32'(bus3.out_data), 32'h3C);
      check("n3_wrap", 32'(bus3.in_ready), 32'h1);
      @(posedge clk);
      #1;
      bus3.mode = 1'b0; bus3.ctrl = 2'd3;
      @(negedge clk);
      check("n3_out_data2", 32'(bus3.out_data), 32'h03);
      check("n3_out_src2", 32'(bus3.out_src), 32'd0);
      check("n3_ctrl_oob", 32'(bus3.in_ready), 32'd0);
      @(posedge clk);
      #1;
      bus3.ctrl = 2'd1;
      @(negedge clk);
      check("n3_fx_ch1", 32'(bus3.in_ready), 32'h2);
      @(posedge clk);
      #1;
      bus3.in_valid = '0;
      @(negedge clk);
      check("n3_out_src3", 32'(bus3.out_src), 32'd1);
      check("n3_out_data3", 32'(bus3.out_data), 32'h02);
      check("n3_out_valid3", 32'(bus3.out_valid), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
